// File: rtl/bn_chunked_adder.sv
// bn_chunked_adder
// ----------------
// Multi-cycle N-bit adder/subtractor. Each operation adds K bits per clock
// and passes the carry between chunks through a register, so a result takes
// M = N/K clocks to compute. N must be an integer multiple of K.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer must hold its payload stable
// while valid=1 and ready=0. in_ready is 1 only in IDLE, and out_valid is
// 1 only in DONE. Because of this, one edge never accepts new operands and
// transfers a result at the same time.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; wins over every other input
//   in_valid   X, Y, C_in and sub are presented
//   in_ready   block is idle and can accept operands
//   X, Y       N-bit operands
//   C_in       carry-in (add mode only; ignored when sub=1)
//   sub        0: Z = X + Y + C_in, 1: Z = X - Y
//   Z          N-bit result
//   C_out      carry out of bit N-1
//   overflow   two's-complement signed overflow
//   out_valid  Z, C_out and overflow are valid
//   out_ready  consumer accepts the result
//   dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2)
module bn_chunked_adder #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         C_in,
    input  logic         sub,
    output logic [N-1:0] Z,
    output logic         C_out,
    output logic         overflow,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   dbg_state
);

    localparam int M  = N / K;
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic [N-1:0]  x_q;
    logic [N-1:0]  y_q;     // already inverted for subtract
    logic          carry;   // carry into the current chunk

    logic [K-1:0]  chunk_x;
    logic [K-1:0]  chunk_y;
    logic [K:0]    chunk_sum;
    logic          carry_msb;  // carry into the top bit of this chunk
    logic          last_chunk;

    // Subtract is X + ~Y + 1: Y is inverted when latched and the initial
    // carry is forced to 1, so RUN only ever performs an add.
    assign chunk_x    = x_q[idx*K +: K];
    assign chunk_y    = y_q[idx*K +: K];
    assign chunk_sum  = {1'b0, chunk_x} + {1'b0, chunk_y} + {{K{1'b0}}, carry};
    assign carry_msb  = chunk_x[K-1] ^ chunk_y[K-1] ^ chunk_sum[K-1];
    assign last_chunk = (idx == IW'(M - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            carry    <= 1'b0;
            Z        <= '0;
            C_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q   <= X;
                        y_q   <= sub ? ~Y : Y;
                        carry <= sub ? 1'b1 : C_in;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    Z[idx*K +: K] <= chunk_sum[K-1:0];
                    carry         <= chunk_sum[K];
                    idx           <= last_chunk ? '0 : idx + IW'(1);
                    // Only the final chunk sees bit N-1, so flags are
                    // captured there and then held through DONE and IDLE.
                    if (last_chunk) begin
                        C_out    <= chunk_sum[K];
                        overflow <= chunk_sum[K] ^ carry_msb;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bn_chunked_adder.sv
// Directed plus randomized bench for bn_chunked_adder at N=8, K=4 (M=2).
module tb_bn_chunked_adder;

  localparam int N = 8;
  localparam int K = 4;
  localparam int M = N / K;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         C_in;
  logic         sub;
  logic [N-1:0] Z;
  logic         C_out;
  logic         overflow;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {C_out, overflow, Z} per accepted operation
  logic [N+1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  bn_chunked_adder #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .C_in      (C_in),
    .sub       (sub),
    .Z         (Z),
    .C_out     (C_out),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic, signed overflow judged by
  // whether the true signed result fits in N bits.
  function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic ci, input logic sb);
    int a = int'(x);
    int b = sb ? (255 - int'(y)) : int'(y);
    int s = a + b + (sb ? 1 : int'(ci));
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int ideal = sb ? (sx - sy) : (sx + sy + int'(ci));
    logic ov = (ideal > 127) || (ideal < -128);
    return {1'(s / 256), ov, 8'(s % 256)};
  endfunction

  // One full operation. Called just after a rising edge with the DUT idle.
  // 'hold' cycles of backpressure are applied in DONE while new operands
  // are offered; they must neither be accepted nor disturb the result.
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic ci, input logic sb, input int hold);
    logic [N+1:0] e;
    logic [N+1:0] held;
    int cyc;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    X = x; Y = y; C_in = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(model(x, y, ci, sb));
    @(posedge clk); #1;
    check("in_ready_run", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      // inputs scrambled during RUN must be ignored
      X = 8'($urandom); Y = 8'($urandom); C_in = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(M));
    out_ready = 1'b0;
    held = {C_out, overflow, Z};
    for (int h = 0; h < hold; h++) begin
      X = 8'($urandom); Y = 8'($urandom); C_in = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_result", 32'({C_out, overflow, Z}), 32'(held));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    e = exp_q.pop_front();
    check("result", 32'({C_out, overflow, Z}), 32'(e));
    check("in_ready_done", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_xfer", 32'(out_valid), 32'd0);
    check("in_ready_after_xfer", 32'(in_ready), 32'd1);
    check("retained_result", 32'({C_out, overflow, Z}), 32'(e));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    X = '0; Y = '0; C_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z", 32'(Z), 32'd0);
    check("rst_c_out", 32'(C_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // directed corner cases
    run_op(8'h0F, 8'h00, 1'b1, 1'b0, 0);  // carry across chunks -> 0x10
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);  // signed overflow
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);  // wrap with carry out
    run_op(8'h80, 8'h01, 1'b1, 1'b1, 5);  // subtract overflow, C_in ignored, backpressure

    // reset in the middle of an operation, with in_valid high on the reset edge
    X = 8'h35; Y = 8'h42; C_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;           // accept edge E0
    in_valid = 1'b0;
    @(posedge clk); #1;           // E1: first chunk computed
    rst = 1'b1; in_valid = 1'b1; X = 8'hAA; Y = 8'h55;
    @(posedge clk); #1;           // reset edge
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_z", 32'(Z), 32'd0);
    check("midrst_c_out", 32'(C_out), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    check("midrst_no_accept", 32'(in_ready), 32'd1);
    run_op(8'h35, 8'h42, 1'b1, 1'b0, 0);

    // randomized operations
    repeat (25) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
